btn_conditioner: RTL

- Upstream stage of the time-set block. Conditions the four raw push-buttons (inc, dec, left, right) into clean single-cycle pulses on CLK.
- Per button: synchronises, debounces and edge-detects the input.
- Adds hold-to-repeat on inc/dec so a held button steps digits continuously.
- Outputs connect directly to the time-set inc/dec/left/right inputs; the time-set enable also gates this block.

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/btn_conditioner.sv | 112 +++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the time-set push-button conditioning slice.
package btn_pkg;

  localparam int unsigned BTN_INC   = 0;
  localparam int unsigned BTN_DEC   = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter and registered rising-edge event.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic level,
  output logic press_evt
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Level flip and press event land on the same edge.
        r_level <= r_sync[1];
        r_press <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level     = r_level;
  assign press_evt = r_press;

endmodule

// File: rtl/btn_conditioner.sv
// Turns the four raw time-set buttons into registered single-cycle pulses,
// with hold-to-repeat on inc/dec and mutual masking within each pair.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic       btn_inc_raw,
  input  logic       btn_dec_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       inc,
  output logic       dec,
  output logic       left,
  output logic       right,
  output logic [3:0] btn_level
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW      = cnt_w(RPT_MAX);
  localparam logic [TW-1:0] DELAY_LD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE - 1);

  logic [3:0] w_raw;
  logic [3:0] w_level;
  logic [3:0] w_press;
  logic [1:0] w_rep_cand;
  logic [3:0] w_cand;
  logic [3:0] r_out;

  assign w_raw = {btn_right_raw, btn_left_raw, btn_dec_raw, btn_inc_raw};

  for (genvar gb = 0; gb < 4; gb++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLK      (CLK),
      .RESET    (RESET),
      .raw      (w_raw[gb]),
      .level    (w_level[gb]),
      .press_evt(w_press[gb])
    );
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;

    assign w_rep_cand[gi] = enable &&
      (((r_state == ST_IDLE) && w_press[gi]) ||
       (((r_state == ST_WAIT) || (r_state == ST_REPEAT)) && w_level[gi] && (r_timer == '0)));

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_state <= ST_IDLE;
        r_timer <= '0;
      end else if (!enable) begin
        r_state <= ST_IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_press[gi]) begin
              r_timer <= DELAY_LD;
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT, ST_REPEAT: begin
            if (!w_level[gi]) begin
              r_state <= ST_IDLE;
            end else if (r_timer == '0) begin
              r_timer <= RATE_LD;
              r_state <= ST_REPEAT;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_cand[BTN_INC]   = w_rep_cand[BTN_INC];
  assign w_cand[BTN_DEC]   = w_rep_cand[BTN_DEC];
  assign w_cand[BTN_LEFT]  = enable & w_press[BTN_LEFT];
  assign w_cand[BTN_RIGHT] = enable & w_press[BTN_RIGHT];

  // Coincident requests within a pair cancel; FSMs above are unaffected.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out <= '0;
    end else begin
      r_out[BTN_INC]   <= w_cand[BTN_INC]   & ~w_cand[BTN_DEC];
      r_out[BTN_DEC]   <= w_cand[BTN_DEC]   & ~w_cand[BTN_INC];
      r_out[BTN_LEFT]  <= w_cand[BTN_LEFT]  & ~w_cand[BTN_RIGHT];
      r_out[BTN_RIGHT] <= w_cand[BTN_RIGHT] & ~w_cand[BTN_LEFT];
    end
  end

  assign inc       = r_out[BTN_INC];
  assign dec       = r_out[BTN_DEC];
  assign left      = r_out[BTN_LEFT];
  assign right     = r_out[BTN_RIGHT];
  assign btn_level = w_level;

endmodule
